ppu_stream: RTL and testbench
=============================

Name: ppu_stream

Overview:
Parametrised pixel processing unit that produces one pixel beat per output handshake for an H_PIX x V_PIX frame. It sits between the byte-stream source (input handshake) and the VGA output stage (output handshake). It holds a ring line buffer fed from the input stream and selects one of eight pixel-generation modes. It adds true backpressure, frame counting, start-of-frame marking and synchronous frame resync.

Parameters:
PIX_W, 8, pixel/data width in bits
H_PIX, 32, pixels per line (>=2)
V_PIX, 32, lines per frame (>=2)
LINE_DEPTH, 32, line buffer entries (>=2, any value; indices taken modulo LINE_DEPTH)
FRAME_W, 8, frame counter width
MOD_K, 7, modulus for grid modes 4/5 (>=2)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
sync  in  1  frame resync request, level input, rising edge acts
mode  in  3  pixel generation mode
data_i  in  PIX_W  input stream byte
stb_i  in  1  input beat valid
ack_i  out  1  input beat accepted, registered
data_o  out  PIX_W  output pixel
stb_o  out  1  output pixel valid
ack_o  in  1  output pixel consumed
sof_o  out  1  qualifies data_o as pixel (0,0), valid with stb_o
frame_o  out  FRAME_W  completed-frame count, wraps

Behaviour:
- Reset (rst sampled high at clk edge): data_o=0, stb_o=0, ack_i=0, sof_o=0, frame_o=0. h, v, wr_ptr and sync_q=0. All line buffer entries=0. Any pending beat is dropped.
- Input: no input backpressure. On each edge with stb_i=1, line[wr_ptr]<=data_i, wr_ptr<=(wr_ptr+1) mod LINE_DEPTH, last_in<=data_i.
- ack_i is the registered value of stb_i: it is high in the cycle after each accepted beat. Continuous stb_i gives continuous ack_i.
- Output handshake: a transfer occurs on an edge where stb_o=1 and ack_o=1.
- While stb_o=1 and ack_o=0, data_o and sof_o hold stable and h, v and frame_o do not change.
- On a transfer edge the next pixel is registered, so stb_o stays high. Back-to-back throughput is 1 pixel/clk.
- First stb_o=1 occurs in the first cycle after rst deasserts, carrying pixel (0,0) with sof_o=1.
- Counters advance on transfer only:
  - h increments; at h=H_PIX-1, h wraps to 0 and v increments.
  - At v=V_PIX-1 with h=H_PIX-1, v wraps to 0 and frame_o increments modulo 2^FRAME_W.
- The registered pixel is always computed from the post-advance (h,v,f) and the current mode. A mode change never alters the pending beat.
- Sync: sync_q<=sync; an edge is sync & ~sync_q. On an edge, h, v<=0 (priority over a same-cycle transfer advance). frame_o is unchanged.
  - If no transfer occurs that cycle, the pending beat stays untouched.
  - The next generated pixel is (0,0) with sof_o=1.
  - sync held high does not retrigger.
- Pixel functions, with p=h^v (zero-extended, then truncated to PIX_W), f=frame_o, L[i]=line[i mod LINE_DEPTH]:
  - 0 passthrough: last_in
  - 1 line: L[h]
  - 2 masked line: p!=0 ? L[h] : 0
  - 3 xor: p
  - 4 grid: (p mod MOD_K)==0 ? all-ones : 0
  - 5 animated grid: (((v+f)^h) mod MOD_K)==0 ? all-ones : 0
  - 6 scroll: L[h+f]
  - 7 blank: 0
- Read/write collision on the same line entry in the same cycle returns the old contents (read-before-write).
- Widths: h/v counters use clog2 of H_PIX/V_PIX. Sums for modes 5/6 are computed at full width before the modulo, with no truncation.

Decomposition:
- Package ppu_pkg: mode localparams (MODE_PASS..MODE_BLANK), and a function pix_mod(value,k) shared by modes 4/5.
- Sub-module ppu_line_buffer: parametrised 1W1R ring, synchronous reset clear, write pointer internal, combinational read port with old-data-on-collision.
- The top level holds the counters, sync detect, handshake register and mode mux.

Test Plan:
1. Release rst with mode=3 and ack_o=1 -> data_o 0,1,...,31 on consecutive cycles with sof_o=1 on the first beat only; beat 33 is 1 (h=0,v=1); beat 34 is 0.
2. Mode 3, drop ack_o for 5 cycles at h=7 -> data_o=7 and stb_o=1 held stable for all 5 cycles; on reassert, next beat is 8.
3. Drive stb_i continuously with bytes 0x10..0x2F, then mode=1, ack_o=1 -> ack_i high the cycle after each byte; output 0x10,0x11,...,0x2F; mode=6 after frame_o=1 gives 0x11 first.
4. Run 1024 transfers (defaults) -> frame_o=1 exactly on transfer 1024 and sof_o=1 on beat 1025; at 2^FRAME_W frames frame_o wraps to 0.
5. Pulse sync while pending beat is at h=10,v=3 with ack_o=0 -> pending data unchanged; after ack, next beat is (0,0) with sof_o=1; sync held high 20 cycles causes no further resync.
6. Assert rst for 1 cycle while stb_o=1 and ack_o=0 in mode 1 -> next cycle stb_o=0 and data_o=0; then first beat is (0,0) and mode-1 data reads 0 (buffer cleared).

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: pixel mode codes and the modulus helper shared by the grid modes
package ppu_pkg;
  localparam logic [2:0] MODE_PASS   = 3'd0;
  localparam logic [2:0] MODE_LINE   = 3'd1;
  localparam logic [2:0] MODE_MASK   = 3'd2;
  localparam logic [2:0] MODE_XOR    = 3'd3;
  localparam logic [2:0] MODE_GRID   = 3'd4;
  localparam logic [2:0] MODE_AGRID  = 3'd5;
  localparam logic [2:0] MODE_SCROLL = 3'd6;
  localparam logic [2:0] MODE_BLANK  = 3'd7;
  function automatic logic [31:0] pix_mod(input logic [31:0] value, input int k);
    return value % 32'(k);
  endfunction
endpackage

// File: rtl/ppu_stream_if.sv
// ppu_stream_if: input byte stream, output pixel stream and control inputs of the pixel unit
interface ppu_stream_if #(parameter int PIX_W = 8, parameter int FRAME_W = 8);
  logic               sync;
  logic [2:0]         mode;
  logic [PIX_W-1:0]   data_i;
  logic               stb_i;
  logic               ack_i;
  logic [PIX_W-1:0]   data_o;
  logic               stb_o;
  logic               ack_o;
  logic               sof_o;
  logic [FRAME_W-1:0] frame_o;
  modport master (output sync, mode, data_i, stb_i, ack_o, input ack_i, data_o, stb_o, sof_o, frame_o);
  modport slave  (input sync, mode, data_i, stb_i, ack_o, output ack_i, data_o, stb_o, sof_o, frame_o);
endinterface

// File: rtl/ppu_line_buffer.sv
// ppu_line_buffer: 1W1R ring of DEPTH entries, cleared on reset, combinational read returns pre-write data
module ppu_line_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  assign o_rdata = r_mem[i_raddr];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
    end else if (i_we) begin
      r_mem[r_wr_ptr] <= i_wdata;
      r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ppu_stream.sv
// ppu_stream: frame-scanning pixel generator with a ring line buffer, output backpressure and frame resync
module ppu_stream
  import ppu_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int H_PIX      = 32,
  parameter int V_PIX      = 32,
  parameter int LINE_DEPTH = 32,
  parameter int FRAME_W    = 8,
  parameter int MOD_K      = 7
) (
  input logic         clk,
  input logic         rst,
  ppu_stream_if.slave bus
);
  localparam int HW = $clog2(H_PIX);
  localparam int VW = $clog2(V_PIX);
  localparam int AW = $clog2(LINE_DEPTH);
  logic [HW-1:0]      r_h, w_nh;
  logic [VW-1:0]      r_v, w_nv;
  logic [FRAME_W-1:0] r_f, w_nf;
  logic [PIX_W-1:0]   r_data, r_last, w_pix, w_line, w_p;
  logic               r_stb, r_sof, r_ack, r_sync_q, r_resync;
  logic               w_xfer, w_sedge, w_load, w_restart, w_adv, w_hwrap, w_vwrap;
  logic [AW-1:0]      w_raddr;
  logic [31:0]        w_sum;
  assign w_xfer    = r_stb & bus.ack_o;
  assign w_sedge   = bus.sync & ~r_sync_q;
  assign w_load    = ~r_stb | w_xfer;
  // r_h/r_v are the coordinates of the pending beat; a resync seen while stalled is deferred to the next transfer
  assign w_restart = w_xfer & (w_sedge | r_resync);
  assign w_adv     = w_xfer & ~w_restart;
  assign w_hwrap   = r_h == HW'(H_PIX - 1);
  assign w_vwrap   = r_v == VW'(V_PIX - 1);
  assign w_nh      = w_restart ? '0 : w_adv ? (w_hwrap ? '0 : r_h + 1'b1) : r_h;
  assign w_nv      = w_restart ? '0 : (w_adv && w_hwrap) ? (w_vwrap ? '0 : r_v + 1'b1) : r_v;
  assign w_nf      = r_f + FRAME_W'(w_adv && w_hwrap && w_vwrap);
  assign w_sum     = 32'(w_nh) + ((bus.mode == MODE_SCROLL) ? 32'(w_nf) : 32'd0);
  assign w_raddr   = AW'(w_sum % 32'(LINE_DEPTH));
  assign w_p       = PIX_W'(32'(w_nh) ^ 32'(w_nv));
  ppu_line_buffer #(.W(PIX_W), .DEPTH(LINE_DEPTH), .AW(AW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .i_we    (bus.stb_i),
    .i_wdata (bus.data_i),
    .i_raddr (w_raddr),
    .o_rdata (w_line)
  );
  always_comb begin
    w_pix = '0;
    case (bus.mode)
      MODE_PASS:               w_pix = r_last;
      MODE_LINE, MODE_SCROLL:  w_pix = w_line;
      MODE_MASK:               w_pix = (w_p != '0) ? w_line : '0;
      MODE_XOR:                w_pix = w_p;
      MODE_GRID:               w_pix = (pix_mod(32'(w_p), MOD_K) == 32'd0) ? '1 : '0;
      MODE_AGRID:              w_pix = (pix_mod((32'(w_nv) + 32'(w_nf)) ^ 32'(w_nh), MOD_K) == 32'd0) ? '1 : '0;
      default:                 w_pix = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h      <= '0;
      r_v      <= '0;
      r_f      <= '0;
      r_data   <= '0;
      r_last   <= '0;
      r_stb    <= 1'b0;
      r_sof    <= 1'b0;
      r_ack    <= 1'b0;
      r_sync_q <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_sync_q <= bus.sync;
      r_ack    <= bus.stb_i;
      r_last   <= bus.stb_i ? bus.data_i : r_last;
      r_resync <= w_load ? 1'b0 : (r_resync | w_sedge);
      if (w_load) begin
        r_stb  <= 1'b1;
        r_data <= w_pix;
        r_sof  <= (w_nh == '0) && (w_nv == '0);
        r_h    <= w_nh;
        r_v    <= w_nv;
        r_f    <= w_nf;
      end
    end
  end
  assign bus.ack_i   = r_ack;
  assign bus.data_o  = r_data;
  assign bus.stb_o   = r_stb;
  assign bus.sof_o   = r_sof;
  assign bus.frame_o = r_f;
endmodule

// File: tb/tb_ppu_stream.sv
// tb_ppu_stream: scoreboard bench; a pixel-index reference model predicts beats, a negedge monitor checks them
module tb_ppu_stream;
  localparam int H = 32, V = 32, D = 32, K = 7, FW = 4, PW = 8;
  localparam int NPIX = H * V;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ppu_stream_if #(.PIX_W(PW), .FRAME_W(FW)) bus ();
  ppu_stream #(.PIX_W(PW), .H_PIX(H), .V_PIX(V), .LINE_DEPTH(D), .FRAME_W(FW), .MOD_K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  typedef struct { int d; bit s; int f; } beat_t;
  beat_t q[$];
  int n_cmp = 0, n_bad = 0, wraps = 0;
  int line[D];
  int idx, fr, wp, last_in;
  bit pend, sync_q, resync, exp_ack, armed = 1'b0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pix(input int n, input int f, input int md);
    int h, v, p;
    h = n % H;
    v = n / H;
    p = (h ^ v) & ((1 << PW) - 1);
    case (md)
      0: return last_in;
      1: return line[h % D];
      2: return (p != 0) ? line[h % D] : 0;
      3: return p;
      4: return (p % K == 0) ? (1 << PW) - 1 : 0;
      5: return ((((v + f) ^ h) % K) == 0) ? (1 << PW) - 1 : 0;
      6: return line[(h + f) % D];
      default: return 0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      pend = 1'b0; idx = 0; fr = 0; wp = 0; last_in = 0;
      sync_q = 1'b0; resync = 1'b0; exp_ack = 1'b0;
      foreach (line[i]) line[i] = 0;
      q.delete();
    end else begin
      bit xfer, sedge;
      xfer = pend && bus.ack_o;
      sedge = bus.sync && !sync_q;
      if (!pend || xfer) begin
        if (pend) begin
          if (sedge || resync) idx = 0;
          else begin
            idx++;
            if (idx == NPIX) begin
              idx = 0;
              fr = (fr + 1) % (1 << FW);
              if (fr == 0) wraps++;
            end
          end
        end
        q.push_back('{pix(idx, fr, int'(bus.mode)), idx == 0, fr});
        pend = 1'b1;
        resync = 1'b0;
      end else if (sedge) resync = 1'b1;
      if (bus.stb_i) begin
        line[wp] = int'(bus.data_i);
        wp = (wp + 1) % D;
        last_in = int'(bus.data_i);
      end
      sync_q = bus.sync;
      exp_ack = bus.stb_i;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      check("stb_o", 32'(bus.stb_o), 32'(pend));
      check("ack_i", 32'(bus.ack_i), 32'(exp_ack));
      if (!pend) begin
        check("idle_data", 32'(bus.data_o), 0);
        check("idle_sof", 32'(bus.sof_o), 0);
        check("idle_frame", 32'(bus.frame_o), 0);
      end else if (q.size() == 0) begin
        check("queue_empty", 32'(bus.stb_o), 0);
      end else begin
        check("data_o", 32'(bus.data_o), q[0].d);
        check("sof_o", 32'(bus.sof_o), 32'(q[0].s));
        check("frame_o", 32'(bus.frame_o), q[0].f);
        if (bus.ack_o) void'(q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.mode = 3'd3; bus.ack_o = 1'b1; bus.sync = 1'b0; bus.stb_i = 1'b0; bus.data_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (40) tick();
    bus.ack_o = 1'b0;
    repeat (5) tick();
    bus.ack_o = 1'b1;
    bus.mode = 3'd1;
    for (int i = 0; i < 32; i++) begin
      bus.stb_i = 1'b1;
      bus.data_i = 8'(8'h10 + i);
      tick();
    end
    bus.stb_i = 1'b0;
    repeat (40) tick();
    bus.mode = 3'd6;
    repeat (1100) tick();
    bus.mode = 3'd3; bus.ack_o = 1'b0; bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    repeat (3) tick();
    bus.ack_o = 1'b1;
    repeat (5) tick();
    bus.sync = 1'b1;
    repeat (20) tick();
    bus.sync = 1'b0;
    bus.mode = 3'd1; bus.ack_o = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    bus.ack_o = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 26000; i++) begin
      bus.mode = 3'($urandom_range(0, 7));
      bus.ack_o = ($urandom_range(0, 9) < 9);
      bus.stb_i = 1'($urandom_range(0, 1));
      bus.data_i = 8'($urandom);
      bus.sync = (i < 3000) && ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.sync = 1'b0;
    repeat (2) tick();
    check("frame_wrap_seen", 32'(wraps > 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
